// File: rtl/timer_pkg.sv
// Timer APB register block: shared definitions.
//   Register addresses, TCR/TSR bit positions, prescaler clock-select
//   encoding and the APB interface FSM state type.
package timer_pkg;

    localparam logic [7:0] ADDR_TDR  = 8'h00;
    localparam logic [7:0] ADDR_TCR  = 8'h01;
    localparam logic [7:0] ADDR_TSR  = 8'h02;
    localparam logic [7:0] ADDR_TCNT = 8'h03;

    localparam int TCR_LOAD_BIT = 7;
    localparam int TCR_DOWN_BIT = 5;
    localparam int TCR_EN_BIT   = 4;

    // Implemented TCR bits: load, down, en, cks[1:0]; bits 6,3,2 read 0.
    localparam logic [7:0] TCR_RW_MASK = 8'hB3;

    localparam int TSR_OVF_BIT = 0;
    localparam int TSR_UDF_BIT = 1;

    typedef enum logic [1:0] {
        CKS_DIV2  = 2'b00,
        CKS_DIV4  = 2'b01,
        CKS_DIV8  = 2'b10,
        CKS_DIV16 = 2'b11
    } cks_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } apb_state_e;

endpackage

// File: rtl/timer_apb_if.sv
// APB slave protocol engine for the timer register block.
//   Tracks SETUP/ACCESS phases, inserts WAIT_STATES cycles of pready=0 and
//   produces a single-cycle completion with read/write strobes.
// Ports:
//   pclk, presetn          clock, async active-low reset
//   psel_i, penable_i      APB select / enable
//   pwrite_i               transfer direction
//   pready_o               completion (combinational, one cycle per transfer)
//   wr_en_o, rd_en_o       completion qualified by direction
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no transfer; a SETUP phase on the bus moves us to ST_SETUP
// ST_SETUP  | SETUP was seen last cycle, bus is now in its first ACCESS cycle
// ST_ACCESS | further ACCESS cycles while the wait counter drains
module timer_apb_if
    import timer_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic pclk,
    input  logic presetn,
    input  logic psel_i,
    input  logic penable_i,
    input  logic pwrite_i,
    output logic pready_o,
    output logic wr_en_o,
    output logic rd_en_o
);

    localparam logic [1:0] WAIT_INIT = 2'(WAIT_STATES);

    apb_state_e state_q, state_d;
    logic [1:0] wait_q, wait_d;
    logic       done;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wait_d = WAIT_INIT;
                if (psel_i && !penable_i) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP, ST_ACCESS: begin
                if (!(psel_i && penable_i)) begin
                    // Master abandoned the transfer: drop it with no side
                    // effect, but honour a fresh SETUP if one is already up.
                    wait_d  = WAIT_INIT;
                    state_d = psel_i ? ST_SETUP : ST_IDLE;
                end else if (wait_q == 2'd0) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_d  = wait_q - 2'd1;
                    state_d = ST_ACCESS;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pready_o = done;
    assign wr_en_o  = done && pwrite_i;
    assign rd_en_o  = done && !pwrite_i;

endmodule

// File: rtl/timer_apb_regs.sv
// APB register file for the 8-bit timer counter core.
//   Holds TDR (load value), TCR (control) and TSR (sticky event status),
//   drives load/direction/enable/clock-select to the counter and prescaler.
// Ports:
//   pclk, presetn                       clock, async active-low reset
//   psel, penable, pwrite, paddr, pwdata APB request
//   prdata, pready, pslverr             APB response
//   tdr_o, load_o                       load value and 1-cycle load strobe
//   dir_down_o, en_o, cks_o             counter/prescaler controls
//   tcnt_i, ovf_evt_i, udf_evt_i        live count and wrap events
module timer_apb_regs
    import timer_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [7:0]        tdr_o,
    output logic              load_o,
    output logic              dir_down_o,
    output logic              en_o,
    output logic [1:0]        cks_o,
    input  logic [7:0]        tcnt_i,
    input  logic              ovf_evt_i,
    input  logic              udf_evt_i
);

    logic wr_en, rd_en, done;

    timer_apb_if #(
        .WAIT_STATES(WAIT_STATES)
    ) u_apb_if (
        .pclk     (pclk),
        .presetn  (presetn),
        .psel_i   (psel),
        .penable_i(penable),
        .pwrite_i (pwrite),
        .pready_o (done),
        .wr_en_o  (wr_en),
        .rd_en_o  (rd_en)
    );

    logic hit_tdr, hit_tcr, hit_tsr, hit_tcnt, mapped;

    assign hit_tdr  = (paddr == ADDR_W'(ADDR_TDR));
    assign hit_tcr  = (paddr == ADDR_W'(ADDR_TCR));
    assign hit_tsr  = (paddr == ADDR_W'(ADDR_TSR));
    assign hit_tcnt = (paddr == ADDR_W'(ADDR_TCNT));
    assign mapped   = hit_tdr || hit_tcr || hit_tsr || hit_tcnt;

    logic [7:0] wdata;
    assign wdata = pwdata[7:0];

    logic [7:0] tdr_q, tdr_d;
    logic [7:0] tcr_q, tcr_d;
    logic [1:0] tsr_q, tsr_d;
    logic       load_q, load_d;
    logic [1:0] tsr_clr;

    always_comb begin
        tdr_d   = tdr_q;
        tcr_d   = tcr_q;
        load_d  = 1'b0;
        tsr_clr = 2'b00;
        if (wr_en && hit_tdr) begin
            tdr_d = wdata;
        end
        if (wr_en && hit_tcr) begin
            tcr_d  = wdata & TCR_RW_MASK;
            load_d = wdata[TCR_LOAD_BIT];
        end
        if (wr_en && hit_tsr) begin
            tsr_clr = wdata[1:0];
        end
        // Clear first, then set, so an event in the W1C cycle survives.
        tsr_d = tsr_q & ~tsr_clr;
        tsr_d[TSR_OVF_BIT] = tsr_d[TSR_OVF_BIT] | ovf_evt_i;
        tsr_d[TSR_UDF_BIT] = tsr_d[TSR_UDF_BIT] | udf_evt_i;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tdr_q  <= '0;
            tcr_q  <= '0;
            tsr_q  <= '0;
            load_q <= 1'b0;
        end else begin
            tdr_q  <= tdr_d;
            tcr_q  <= tcr_d;
            tsr_q  <= tsr_d;
            load_q <= load_d;
        end
    end

    logic [7:0] rdata;

    always_comb begin
        rdata = 8'h00;
        if (rd_en) begin
            if (hit_tdr) begin
                rdata = tdr_q;
            end else if (hit_tcr) begin
                rdata = tcr_q;
            end else if (hit_tsr) begin
                rdata = {6'b0, tsr_q};
            end else if (hit_tcnt) begin
                rdata = tcnt_i;
            end
        end
    end

    assign prdata  = DATA_W'(rdata);
    assign pready  = done;
    assign pslverr = done && !mapped;

    assign tdr_o      = tdr_q;
    assign load_o     = load_q;
    assign dir_down_o = tcr_q[TCR_DOWN_BIT];
    assign en_o       = tcr_q[TCR_EN_BIT];
    assign cks_o      = tcr_q[1:0];

endmodule

// File: tb/tb_timer_apb_regs.sv
module tb_timer_apb_regs;

    localparam int WS = 2;

    logic       clk = 1'b0;
    logic       presetn = 1'b0;
    logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0] paddr = '0, pwdata = '0;
    logic [7:0] prdata;
    logic       pready, pslverr;
    logic [7:0] tdr_o;
    logic       load_o, dir_down_o, en_o;
    logic [1:0] cks_o;
    logic [7:0] tcnt_i = '0;
    logic       ovf_evt_i = 1'b0, udf_evt_i = 1'b0;

    always #5 clk = ~clk;

    timer_apb_regs #(
        .ADDR_W(8), .DATA_W(8), .WAIT_STATES(WS)
    ) dut (
        .pclk(clk), .presetn(presetn),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .tdr_o(tdr_o), .load_o(load_o), .dir_down_o(dir_down_o),
        .en_o(en_o), .cks_o(cks_o),
        .tcnt_i(tcnt_i), .ovf_evt_i(ovf_evt_i), .udf_evt_i(udf_evt_i)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: architectural register contents.
    logic [7:0] m_tdr = '0;
    logic [7:0] m_tcr = '0;
    bit         m_ovf = 0, m_udf = 0;

    bit         ev_rand = 0;
    bit         ev_done_ovf = 0;
    logic [7:0] last_rd;
    bit         last_err;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive_ev();
        ovf_evt_i = ev_rand && ($urandom_range(0, 7) == 0);
        udf_evt_i = ev_rand && ($urandom_range(0, 7) == 0);
        tcnt_i    = 8'($urandom);
    endtask

    // Account for the coming rising edge: W1C then events (event wins).
    task automatic model_tick(input logic [1:0] clr);
        if (clr[0]) m_ovf = 0;
        if (clr[1]) m_udf = 0;
        if (ovf_evt_i) m_ovf = 1;
        if (udf_evt_i) m_udf = 1;
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] addr);
        case (addr)
            8'h00:   return m_tdr;
            8'h01:   return {m_tcr[7], 1'b0, m_tcr[5], m_tcr[4], 2'b00, m_tcr[1:0]};
            8'h02:   return {6'b0, m_udf, m_ovf};
            8'h03:   return tcnt_i;
            default: return 8'h00;
        endcase
    endfunction

    task automatic apb_xfer(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                            input bit abort);
        int   waits = 0;
        bit   done = 0;
        bit   aborted = 0;
        bit   exp_load = 0;
        logic [1:0] clr;
        @(negedge clk);
        #1;
        check_eq("load_idle", load_o, 0);
        psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = data;
        drive_ev();
        #1;
        check_eq("pready_setup", pready, 0);
        model_tick(2'b00);
        @(negedge clk);
        penable = 1;
        drive_ev();
        for (int c = 0; c < 16; c++) begin
            #1;
            if (pready) begin
                if (ev_done_ovf) ovf_evt_i = 1;
                last_rd  = prdata;
                last_err = pslverr;
                check_eq("wait_cycles", waits, WS);
                check_eq("pslverr", pslverr, (addr > 8'h03));
                if (!wr) check_eq("prdata", prdata, model_read(addr));
                clr = 2'b00;
                if (wr) begin
                    case (addr)
                        8'h00: m_tdr = data;
                        8'h01: begin m_tcr = data; exp_load = data[7]; end
                        8'h02: clr = data[1:0];
                        default: ;
                    endcase
                end
                model_tick(clr);
                done = 1;
                break;
            end
            waits++;
            model_tick(2'b00);
            @(negedge clk);
            drive_ev();
            if (abort && waits == 1) begin
                psel = 0; penable = 0;
                #1;
                check_eq("pready_abort", pready, 0);
                model_tick(2'b00);
                aborted = 1;
                break;
            end
        end
        if (!done && !aborted) check_eq("xfer_timeout", 1, 0);
        @(negedge clk);
        psel = 0; penable = 0;
        drive_ev();
        #1;
        check_eq("load_o", load_o, exp_load);
        check_eq("tdr_o", tdr_o, m_tdr);
        check_eq("en_o", en_o, m_tcr[4]);
        check_eq("dir_down_o", dir_down_o, m_tcr[5]);
        check_eq("cks_o", cks_o, m_tcr[1:0]);
        model_tick(2'b00);
    endtask

    task automatic pulse_ovf();
        @(negedge clk);
        ovf_evt_i = 1; udf_evt_i = 0;
        model_tick(2'b00);
        @(negedge clk);
        ovf_evt_i = 0;
        model_tick(2'b00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_pready", pready, 0);
        check_eq("rst_pslverr", pslverr, 0);
        check_eq("rst_prdata", prdata, 0);
        check_eq("rst_load", load_o, 0);
        check_eq("rst_tdr", tdr_o, 0);
        @(negedge clk);
        presetn = 1;

        // 1: reset in the middle of a TDR write
        apb_xfer(1, 8'h00, 8'h55, 0);
        apb_xfer(1, 8'h01, 8'h33, 0);
        @(negedge clk);
        psel = 1; penable = 0; pwrite = 1; paddr = 8'h00; pwdata = 8'hAA;
        @(negedge clk);
        penable = 1;
        #2 presetn = 0;
        #1;
        check_eq("t1_pready_in_rst", pready, 0);
        check_eq("t1_tdr_cleared", tdr_o, 0);
        check_eq("t1_en_cleared", en_o, 0);
        psel = 0; penable = 0;
        m_tdr = 0; m_tcr = 0; m_ovf = 0; m_udf = 0;
        repeat (2) @(negedge clk);
        presetn = 1;
        apb_xfer(0, 8'h00, 8'h00, 0);
        check_eq("t1_tdr_read", last_rd, 8'h00);
        apb_xfer(0, 8'h01, 8'h00, 0);
        check_eq("t1_tcr_read", last_rd, 8'h00);
        check_eq("t1_pslverr", last_err, 0);

        // 2: controls and TSR OVF set / W1C
        apb_xfer(1, 8'h01, 8'h11, 0);
        check_eq("t2_en", en_o, 1);
        check_eq("t2_cks", cks_o, 2'b01);
        check_eq("t2_dir", dir_down_o, 0);
        pulse_ovf();
        apb_xfer(0, 8'h02, 8'h00, 0);
        check_eq("t2_tsr_set", last_rd, 8'h01);
        apb_xfer(1, 8'h02, 8'h01, 0);
        apb_xfer(0, 8'h02, 8'h00, 0);
        check_eq("t2_tsr_clr", last_rd, 8'h00);

        // 3: load of a freshly written TDR
        apb_xfer(1, 8'h00, 8'hF0, 0);
        apb_xfer(1, 8'h01, 8'hB0, 0);
        check_eq("t3_tdr_o", tdr_o, 8'hF0);
        check_eq("t3_dir", dir_down_o, 1);
        apb_xfer(0, 8'h01, 8'h00, 0);
        check_eq("t3_tcr_read", last_rd, 8'hB0);

        // 4: event coincident with W1C completion keeps the bit set
        ev_done_ovf = 1;
        apb_xfer(1, 8'h02, 8'h01, 0);
        ev_done_ovf = 0;
        apb_xfer(0, 8'h02, 8'h00, 0);
        check_eq("t4_set_wins", last_rd, 8'h01);

        // 5: unmapped address
        apb_xfer(0, 8'h07, 8'h00, 0);
        check_eq("t5_err", last_err, 1);
        check_eq("t5_rd", last_rd, 8'h00);
        apb_xfer(1, 8'h07, 8'hFF, 0);
        apb_xfer(0, 8'h00, 8'h00, 0);
        check_eq("t5_tdr_kept", last_rd, 8'hF0);
        apb_xfer(0, 8'h01, 8'h00, 0);
        check_eq("t5_tcr_kept", last_rd, 8'hB0);

        // Abort mid-ACCESS: no side effect
        apb_xfer(1, 8'h00, 8'h12, 1);
        apb_xfer(0, 8'h00, 8'h00, 0);
        check_eq("abort_tdr_kept", last_rd, 8'hF0);

        // Randomised traffic against the model
        ev_rand = 1;
        for (int i = 0; i < 300; i++) begin
            logic [7:0] a;
            a = (($urandom_range(0, 7) == 0) ? 8'($urandom_range(4, 255))
                                             : 8'($urandom_range(0, 3)));
            apb_xfer(1'($urandom_range(0, 1)), a, 8'($urandom),
                     ($urandom_range(0, 15) == 0));
        end
        ev_rand = 0;
        ovf_evt_i = 0; udf_evt_i = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
